// File: rtl/rtsnoc_echo_mp.sv
// rtsnoc_echo_mp: multi-channel buffered echo endpoint for the RTSNoC router.
//
// Each channel reads flits from its router port, swaps the source and destination
// header fields, queues the result in a private FIFO and writes it back to the router.
// Channels share nothing except the clock and the synchronised reset.
//
// Ports:
//   clk_i       clock, rising edge
//   rst_ni      asynchronous active-low reset; release is synchronised internally
//   din_o       flit to router, channel c at [c*BUS +: BUS]
//   wr_o        write strobe per channel
//   wait_i      router busy per channel; a write completes only when low
//   rd_o        read strobe per channel
//   dout_i      flit from router, valid the cycle after rd_o
//   nd_i        new data available per channel
//
// Optional (macro RTSNOC_ECHO_STATS_EN):
//   echo_cnt_o  16-bit wrapping count of completed writes per channel
//   ovf_o       sticky flag per channel: nd_i seen while the FIFO was full

module rtsnoc_echo_mp #(
  parameter int unsigned SOC_SIZE_X      = 1,
  parameter int unsigned SOC_SIZE_Y      = 1,
  parameter int unsigned NOC_DATA_WIDTH  = 16,
  parameter int unsigned N_CHANNELS      = 2,
  parameter int unsigned FIFO_DEPTH_LOG2 = 2,
  localparam int unsigned BUS = NOC_DATA_WIDTH + 2 * SOC_SIZE_X + 2 * SOC_SIZE_Y + 6
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  output logic [N_CHANNELS*BUS-1:0]  din_o,
  output logic [N_CHANNELS-1:0]      wr_o,
  input  logic [N_CHANNELS-1:0]      wait_i,
  output logic [N_CHANNELS-1:0]      rd_o,
  input  logic [N_CHANNELS*BUS-1:0]  dout_i,
  input  logic [N_CHANNELS-1:0]      nd_i
`ifdef RTSNOC_ECHO_STATS_EN
  ,
  output logic [N_CHANNELS*16-1:0]   echo_cnt_o,
  output logic [N_CHANNELS-1:0]      ovf_o
`endif
);

  localparam int unsigned AW    = FIFO_DEPTH_LOG2;
  localparam int unsigned CntW  = FIFO_DEPTH_LOG2 + 1;
  localparam int unsigned Depth = 1 << FIFO_DEPTH_LOG2;

  // LSB positions of the header fields inside a flit
  localparam int unsigned DlLsb = NOC_DATA_WIDTH;
  localparam int unsigned SlLsb = NOC_DATA_WIDTH + 3;
  localparam int unsigned DyLsb = NOC_DATA_WIDTH + 6;
  localparam int unsigned DxLsb = DyLsb + SOC_SIZE_Y;
  localparam int unsigned SyLsb = DxLsb + SOC_SIZE_X;
  localparam int unsigned SxLsb = SyLsb + SOC_SIZE_Y;

  typedef enum logic {
    RxIdle,
    RxCapt
  } rx_state_e;

  // Reset asserts immediately but releases two clocks later, aligned to clk_i.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_n = rst_sync_q[1];

  for (genvar c = 0; c < N_CHANNELS; c++) begin : g_ch
    rx_state_e         rx_q, rx_d;
    logic [BUS-1:0]    flit_in;
    logic [BUS-1:0]    flit_echo;
    logic [BUS-1:0]    mem [Depth];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q, rd_ptr_nxt;
    logic [CntW-1:0]   cnt_q;
    logic              full, empty;
    logic              push, pop, rd;
    logic              wr_q, wr_d;
    logic [BUS-1:0]    din_q, din_d;

    assign flit_in   = dout_i[c*BUS +: BUS];
    assign flit_echo = {flit_in[DxLsb +: SOC_SIZE_X], flit_in[DyLsb +: SOC_SIZE_Y],
                        flit_in[SxLsb +: SOC_SIZE_X], flit_in[SyLsb +: SOC_SIZE_Y],
                        flit_in[DlLsb +: 3], flit_in[SlLsb +: 3],
                        flit_in[NOC_DATA_WIDTH-1:0]};

    assign full       = (cnt_q == CntW'(Depth));
    assign empty      = (cnt_q == '0);
    assign rd_ptr_nxt = rd_ptr_q + 1'b1;
    // wr_q implies the displayed flit is still the FIFO head, so pop never underflows.
    assign pop        = wr_q & ~wait_i[c];

    // Receive engine. rd is gated by reset so it stays low while held in reset.
    always_comb begin
      rx_d = rx_q;
      rd   = 1'b0;
      push = 1'b0;
      case (rx_q)
        RxIdle: begin
          if (rst_n && nd_i[c] && !full) begin
            rd   = 1'b1;
            rx_d = RxCapt;
          end
        end
        RxCapt: begin
          push = 1'b1;
          rx_d = RxIdle;
        end
        default: rx_d = RxIdle;
      endcase
    end

    // Transmit engine: din_q mirrors the FIFO head while wr_q is set.
    always_comb begin
      wr_d  = wr_q;
      din_d = din_q;
      if (!wr_q) begin
        if (!empty) begin
          wr_d  = 1'b1;
          din_d = mem[rd_ptr_q];
        end
      end else if (pop) begin
        if (cnt_q > CntW'(1)) begin
          wr_d  = 1'b1;
          din_d = mem[rd_ptr_nxt];
        end else if (push) begin
          // Last entry leaves as a new one arrives: forward it to keep writes back-to-back.
          wr_d  = 1'b1;
          din_d = flit_echo;
        end else begin
          wr_d  = 1'b0;
        end
      end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
        rx_q     <= RxIdle;
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        cnt_q    <= '0;
        wr_q     <= 1'b0;
        din_q    <= '0;
      end else begin
        rx_q  <= rx_d;
        wr_q  <= wr_d;
        din_q <= din_d;
        if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_q <= rd_ptr_nxt;
        case ({push, pop})
          2'b10:   cnt_q <= cnt_q + 1'b1;
          2'b01:   cnt_q <= cnt_q - 1'b1;
          default: cnt_q <= cnt_q;
        endcase
      end
    end

    // Storage carries no reset; validity is tracked by the pointers and count.
    // A push into a full FIFO only happens with a pop, which has already read the head.
    always_ff @(posedge clk_i) begin
      if (push) mem[wr_ptr_q] <= flit_echo;
    end

    assign rd_o[c]              = rd;
    assign wr_o[c]              = wr_q;
    assign din_o[c*BUS +: BUS]  = din_q;

`ifdef RTSNOC_ECHO_STATS_EN
    logic [15:0] echo_cnt_q;
    logic        ovf_q;

    always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
        echo_cnt_q <= '0;
        ovf_q      <= 1'b0;
      end else begin
        if (pop)              echo_cnt_q <= echo_cnt_q + 16'd1;
        if (nd_i[c] && full)  ovf_q      <= 1'b1;
      end
    end

    assign echo_cnt_o[c*16 +: 16] = echo_cnt_q;
    assign ovf_o[c]               = ovf_q;
`endif
  end

endmodule

// File: tb/tb_rtsnoc_echo_mp.sv
// Directed testbench for rtsnoc_echo_mp at default parameters (2 channels, depth 4,
// 26-bit flits). A small router model feeds queued flits on rd_o and logs completed
// writes; the main sequence checks timing, ordering, backpressure and reset.

module tb_rtsnoc_echo_mp;

  localparam int NCH = 2;
  localparam int BUS = 26;

  logic               clk_i;
  logic               rst_ni;
  logic [NCH*BUS-1:0] din_o;
  logic [NCH-1:0]     wr_o;
  logic [NCH-1:0]     wait_i;
  logic [NCH-1:0]     rd_o;
  logic [NCH*BUS-1:0] dout_i;
  logic [NCH-1:0]     nd_i;
`ifdef RTSNOC_ECHO_STATS_EN
  logic [NCH*16-1:0]  echo_cnt_o;
  logic [NCH-1:0]     ovf_o;
`endif

  rtsnoc_echo_mp dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .din_o      (din_o),
    .wr_o       (wr_o),
    .wait_i     (wait_i),
    .rd_o       (rd_o),
    .dout_i     (dout_i),
    .nd_i       (nd_i)
`ifdef RTSNOC_ECHO_STATS_EN
    ,
    .echo_cnt_o (echo_cnt_o),
    .ovf_o      (ovf_o)
`endif
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Fields listed MSB first: src_x, src_y, dst_x, dst_y, src_local, dst_local, data
  function automatic logic [BUS-1:0] mk(input int sx, input int sy, input int dx, input int dy,
                                        input int sl, input int dl, input int data);
    return {1'(sx), 1'(sy), 1'(dx), 1'(dy), 3'(sl), 3'(dl), 16'(data)};
  endfunction

  // Router model state
  logic [BUS-1:0] rq [NCH][32];
  int             rq_head [NCH];
  int             rq_tail [NCH];
  logic [BUS-1:0] lg [NCH][64];
  int             lg_n [NCH];

  task automatic enq(input int c, input logic [BUS-1:0] f);
    rq[c][rq_tail[c]] = f;
    rq_tail[c]++;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #2;
  endtask

  task automatic wait_log(input int c, input int n, input int budget);
    int k;
    k = 0;
    while (lg_n[c] < n && k < budget) begin
      tick(1);
      k++;
    end
    check("log_count", 64'(lg_n[c]), 64'(n));
  endtask

  // Router model: serve reads, log completed writes, check stall stability.
  initial begin
    logic [NCH-1:0] rd_s;
    logic [NCH-1:0] stall_prev;
    logic [BUS-1:0] prev_din [NCH];
    dout_i     = '0;
    nd_i       = '0;
    stall_prev = '0;
    for (int c = 0; c < NCH; c++) begin
      rq_head[c]  = 0;
      rq_tail[c]  = 0;
      lg_n[c]     = 0;
      prev_din[c] = '0;
    end
    forever begin
      @(negedge clk_i);
      rd_s = rd_o;
      for (int c = 0; c < NCH; c++) begin
        if (stall_prev[c] && rst_ni) begin
          check("stall_wr_hold", 64'(wr_o[c]), 64'd1);
          check("stall_din_hold", 64'(din_o[c*BUS +: BUS]), 64'(prev_din[c]));
        end
        if (wr_o[c] && !wait_i[c]) begin
          lg[c][lg_n[c]] = din_o[c*BUS +: BUS];
          lg_n[c]++;
        end
        stall_prev[c] = wr_o[c] & wait_i[c];
        prev_din[c]   = din_o[c*BUS +: BUS];
      end
      @(posedge clk_i);
      #1;
      for (int c = 0; c < NCH; c++) begin
        if (rd_s[c]) begin
          dout_i[c*BUS +: BUS] = rq[c][rq_head[c]];
          rq_head[c]++;
        end
        nd_i[c] = (rq_head[c] != rq_tail[c]);
      end
    end
  end

  initial begin
    int  k;
    int  base;
    bit  found;

    // Reset state
    rst_ni = 1'b0;
    wait_i = '0;
    #3;
    check("reset_wr", 64'(wr_o), 64'd0);
    check("reset_rd", 64'(rd_o), 64'd0);
    check("reset_din", 64'(din_o), 64'd0);
    tick(3);
    rst_ni = 1'b1;
    tick(5);
    check("idle_wr", 64'(wr_o), 64'd0);

    // Single echo with latency check
    enq(0, 26'h255BEEF);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick(1);
      if (rd_o[0]) found = 1;
    end
    check("echo_rd_seen", 64'(found), 64'd1);
    tick(1);
    check("echo_rd_pulse", 64'(rd_o[0]), 64'd0);
    k = 1;
    while (!wr_o[0] && k < 20) begin
      tick(1);
      k++;
    end
    check("echo_latency", 64'(k), 64'd3);
    check("echo_din", 64'(din_o[BUS-1:0]), 64'h1AABEEF);
    tick(1);
    check("echo_wr_drop", 64'(wr_o[0]), 64'd0);
    check("echo_log_n", 64'(lg_n[0]), 64'd1);
    check("echo_log_val", 64'(lg[0][0]), 64'h1AABEEF);

    // Backpressure: 4 queued, 2 left pending at the router
    wait_i[0] = 1'b1;
    base = lg_n[0];
    for (int i = 1; i <= 6; i++) enq(0, mk(1, 1, 0, 0, 3, 4, i));
    tick(30);
    check("bp_rd_low", 64'(rd_o[0]), 64'd0);
    check("bp_nd_pending", 64'(nd_i[0]), 64'd1);
    check("bp_pending_cnt", 64'(rq_tail[0] - rq_head[0]), 64'd2);
    check("bp_wr_held", 64'(wr_o[0]), 64'd1);
    check("bp_din_head", 64'(din_o[BUS-1:0]), 64'(mk(0, 0, 1, 1, 4, 3, 1)));
`ifdef RTSNOC_ECHO_STATS_EN
    check("bp_ovf", 64'(ovf_o[0]), 64'd1);
`endif
    wait_i[0] = 1'b0;
    wait_log(0, base + 6, 80);
    for (int i = 1; i <= 6; i++)
      check("bp_order", 64'(lg[0][base+i-1]), 64'(mk(0, 0, 1, 1, 4, 3, i)));

    // Back-to-back drain of a full FIFO
    wait_i[0] = 1'b1;
    base = lg_n[0];
    for (int i = 0; i < 4; i++) enq(0, mk(1, 0, 1, 0, 6, 1, 16'h11 + i));
    tick(20);
    check("b2b_wr_pre", 64'(wr_o[0]), 64'd1);
    check("b2b_din0", 64'(din_o[BUS-1:0]), 64'(mk(1, 0, 1, 0, 1, 6, 16'h11)));
    wait_i[0] = 1'b0;
    for (int i = 1; i < 4; i++) begin
      tick(1);
      check("b2b_wr", 64'(wr_o[0]), 64'd1);
      check("b2b_din", 64'(din_o[BUS-1:0]), 64'(mk(1, 0, 1, 0, 1, 6, 16'h11 + i)));
    end
    tick(1);
    check("b2b_wr_end", 64'(wr_o[0]), 64'd0);
    check("b2b_log_n", 64'(lg_n[0]), 64'(base + 4));

    // Full FIFO with toggling wait_i: pushes and pops coincide
    wait_i[0] = 1'b1;
    base = lg_n[0];
    for (int i = 0; i < 6; i++) enq(0, mk(0, 1, 1, 1, 2, 7, 16'h21 + i));
    tick(30);
    for (int i = 0; i < 40; i++) begin
      wait_i[0] = i[0];
      tick(1);
    end
    wait_i[0] = 1'b0;
    wait_log(0, base + 6, 60);
    for (int i = 0; i < 6; i++)
      check("pp_order", 64'(lg[0][base+i]), 64'(mk(1, 1, 0, 1, 7, 2, 16'h21 + i)));

    // Channel independence
    wait_i[1] = 1'b1;
    base = lg_n[0];
    enq(0, mk(1, 1, 1, 0, 5, 0, 16'h1234));
    wait_log(0, base + 1, 30);
    check("ind_ch0_val", 64'(lg[0][base]), 64'(mk(1, 0, 1, 1, 0, 5, 16'h1234)));
    check("ind_ch1_wr", 64'(wr_o[1]), 64'd0);
    check("ind_ch1_rd", 64'(rd_o[1]), 64'd0);
    check("ind_ch1_din", 64'(din_o[2*BUS-1:BUS]), 64'd0);
    check("ind_ch1_log", 64'(lg_n[1]), 64'd0);
`ifdef RTSNOC_ECHO_STATS_EN
    check("stat_cnt0", 64'(echo_cnt_o[15:0]), 64'd18);
    check("stat_cnt1", 64'(echo_cnt_o[31:16]), 64'd0);
`endif
    wait_i[1] = 1'b0;

    // Reset mid-operation with flits queued
    wait_i[0] = 1'b1;
    for (int i = 0; i < 3; i++) enq(0, mk(1, 0, 0, 1, 3, 3, 16'h31 + i));
    tick(15);
    check("rst_pre_wr", 64'(wr_o[0]), 64'd1);
    #1;
    rst_ni = 1'b0;
    #1;
    check("rst_async_wr", 64'(wr_o), 64'd0);
    check("rst_async_rd", 64'(rd_o), 64'd0);
    check("rst_async_din", 64'(din_o), 64'd0);
    for (int c = 0; c < NCH; c++) rq_head[c] = rq_tail[c];
    wait_i = '0;
    base = lg_n[0];
    tick(3);
    rst_ni = 1'b1;
    tick(20);
    check("rst_no_stale", 64'(lg_n[0]), 64'(base));
    check("rst_post_wr", 64'(wr_o), 64'd0);
`ifdef RTSNOC_ECHO_STATS_EN
    check("rst_cnt", 64'(echo_cnt_o), 64'd0);
    check("rst_ovf", 64'(ovf_o), 64'd0);
`endif

    // Echo still works after reset
    enq(0, mk(0, 0, 1, 1, 1, 2, 16'h55AA));
    wait_log(0, base + 1, 30);
    check("post_rst_val", 64'(lg[0][base]), 64'(mk(1, 1, 0, 0, 2, 1, 16'h55AA)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time limit so the bench can never hang
  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1);
  end

endmodule
